// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Instructions are 4-byte big-endian words; the FSM either fetches or sits faulted.
package imem_fetch_ctrl_pkg;

    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// DEPTH-entry {pc, instr} prefetch FIFO; head is registered storage, visible the cycle after push.
// Push is ignored when full unless a pop frees the slot in the same cycle; flush wins over push/pop.
module imem_fetch_ctrl_fetch_queue
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_pc,
    input  logic [INSTR_W-1:0]       push_instr,
    input  logic                     pop,
    output logic [ADDR_W-1:0]        head_pc,
    output logic [INSTR_W-1:0]       head_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               empty;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (do_push) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns fetch_pc, reads combinational imem, queues words for decode (1 cycle latency).
// Fetch stalls while the queue is full and decode is not ready; redirect flushes and restarts.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int              ADDR_W     = 64,
    parameter int              DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              IMEM_BYTES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INSTR_W-1:0]  inst_data,
    output logic [ADDR_W-1:0]   inst_pc,
    output logic                fault,
    output logic [ADDR_W-1:0]   fault_pc
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IMEM_BYTES - INSTR_BYTES);

    state_t                 state;
    state_t                 state_nxt;
    logic [ADDR_W-1:0]      fetch_pc;
    logic [ADDR_W-1:0]      fetch_pc_nxt;
    logic                   fault_nxt;
    logic [ADDR_W-1:0]      fault_pc_nxt;
    logic                   bad;
    logic                   push;
    logic                   pop;
    logic                   q_full;
    logic [$clog2(DEPTH):0] q_count;

    assign imem_addr  = fetch_pc;
    assign bad        = (fetch_pc[1:0] != 2'b00) || (fetch_pc > LAST_PC);
    assign inst_valid = (q_count != '0);
    assign pop        = inst_valid & inst_ready & ~redirect_valid;
    assign push       = (state == ST_FETCH) & ~bad & ~redirect_valid & (~q_full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            fetch_pc <= RESET_PC;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            fault    <= fault_nxt;
            fault_pc <= fault_pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        fault_nxt    = fault;
        fault_pc_nxt = fault_pc;
        if (redirect_valid) begin
            state_nxt    = ST_FETCH;
            fetch_pc_nxt = redirect_pc;
            fault_nxt    = 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (bad) begin
                        state_nxt    = ST_FAULT;
                        fault_nxt    = 1'b1;
                        fault_pc_nxt = fetch_pc;
                    end else if (push) begin
                        // Overflow wraps silently; the range check catches it next cycle.
                        fetch_pc_nxt = fetch_pc + ADDR_W'(INSTR_BYTES);
                    end
                end
                ST_FAULT: ;
                default:  state_nxt = ST_FETCH;
            endcase
        end
    end

    imem_fetch_ctrl_fetch_queue #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_pc    (fetch_pc),
        .push_instr (imem_instr),
        .pop        (pop),
        .head_pc    (inst_pc),
        .head_instr (inst_data),
        .count      (q_count),
        .full       (q_full)
    );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl; word at pc p is {A0,B1,C2,p[7:0]} big-endian.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        fault;
    logic [63:0] fault_pc;

    logic [7:0]  mem [64];
    int          ia;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .ADDR_W     (64),
        .DEPTH      (4),
        .RESET_PC   (64'h0),
        .IMEM_BYTES (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    always_comb begin
        ia = int'(imem_addr[5:0]);
        if (imem_addr <= 64'd60)
            imem_instr = {mem[ia], mem[ia+1], mem[ia+2], mem[ia+3]};
        else
            imem_instr = 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [63:0] p);
        return 32'hA0B1_C200 | {24'h0, p[7:0]};
    endfunction

    task automatic expect_head(input string tag, input logic [63:0] pc);
        chk({tag, "_vld"}, 64'(inst_valid), 64'd1);
        chk({tag, "_pc"},  inst_pc, pc);
        chk({tag, "_dat"}, 64'(inst_data), 64'(word(pc)));
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = rdy;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int p = 0; p < 64; p += 4) begin
            mem[p]   = 8'hA0;
            mem[p+1] = 8'hB1;
            mem[p+2] = 8'hC2;
            mem[p+3] = 8'(p);
        end
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;

        @(negedge clk);
        chk("rst_vld",   64'(inst_valid), 64'd0);
        chk("rst_dat",   64'(inst_data), 64'd0);
        chk("rst_pc",    inst_pc, 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_fpc",   fault_pc, 64'd0);
        chk("rst_addr",  imem_addr, 64'd0);
        rst_n = 1'b1;

        // Full stream, one per cycle, then run off the end of memory.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            expect_head($sformatf("stream%0d", i), 64'(4 * i));
        end
        @(negedge clk);
        chk("end_vld",   64'(inst_valid), 64'd0);
        chk("end_fault", 64'(fault), 64'd1);
        chk("end_fpc",   fault_pc, 64'h40);
        chk("end_addr",  imem_addr, 64'h40);
        repeat (3) @(negedge clk);
        chk("end_hold_vld",  64'(inst_valid), 64'd0);
        chk("end_hold_addr", imem_addr, 64'h40);

        // Stall from reset: exactly four pushes, then drain in order.
        do_reset(1'b0);
        repeat (10) @(negedge clk);
        chk("stall_addr", imem_addr, 64'h10);
        expect_head("stall_head", 64'h0);
        inst_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            expect_head($sformatf("drain%0d", k), 64'(4 * k));
        end

        // Asynchronous reset with a full queue.
        do_reset(1'b0);
        repeat (6) @(negedge clk);
        expect_head("full_head", 64'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld",   64'(inst_valid), 64'd0);
        chk("arst_dat",   64'(inst_data), 64'd0);
        chk("arst_pc",    inst_pc, 64'd0);
        chk("arst_addr",  imem_addr, 64'd0);
        chk("arst_fault", 64'(fault), 64'd0);
        @(negedge clk);
        inst_ready = 1'b1;
        rst_n      = 1'b1;
        @(negedge clk);
        expect_head("arst_r0", 64'h0);
        @(negedge clk);
        expect_head("arst_r1", 64'h4);

        // Redirect with three queued entries and decode ready.
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        chk("pre_redir_addr", imem_addr, 64'hC);
        expect_head("pre_redir", 64'h0);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h20;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("redir_vld",  64'(inst_valid), 64'd0);
        chk("redir_addr", imem_addr, 64'h20);
        @(negedge clk);
        expect_head("redir0", 64'h20);
        @(negedge clk);
        expect_head("redir1", 64'h24);

        // Misaligned redirect faults; a good redirect recovers.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h22;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("mis_vld0",   64'(inst_valid), 64'd0);
        chk("mis_fault0", 64'(fault), 64'd0);
        @(negedge clk);
        chk("mis_fault", 64'(fault), 64'd1);
        chk("mis_fpc",   fault_pc, 64'h22);
        chk("mis_vld1",  64'(inst_valid), 64'd0);
        chk("mis_addr",  imem_addr, 64'h22);
        @(negedge clk);
        chk("mis_vld2", 64'(inst_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h08;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("rec_fault", 64'(fault), 64'd0);
        chk("rec_vld",   64'(inst_valid), 64'd0);
        chk("rec_addr",  imem_addr, 64'h08);
        @(negedge clk);
        expect_head("rec0", 64'h08);
        @(negedge clk);
        expect_head("rec1", 64'h0C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction fetch sequencer in front of the byte-addressed, combinational-read instruction memory (64 bytes, big-endian, 4-byte words). Owns the fetch PC and drives the memory address each cycle. Captures returned words into a small prefetch queue and presents {pc, instruction} to decode over a valid/ready handshake. Handles branch redirects (flush and refetch) and flags misaligned or out-of-range fetch addresses.

Parameters:
ADDR_W, 64, width of PC and memory address
DEPTH, 4, prefetch queue entries; power of 2, >= 2
RESET_PC, 0, fetch PC loaded on reset
IMEM_BYTES, 64, instruction memory size in bytes; multiple of 4

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_addr  out  ADDR_W  byte address to instruction memory; always equals fetch_pc
imem_instr  in  32  instruction word for imem_addr, valid same cycle
redirect_valid  in  1  branch/jump taken; flush and restart at redirect_pc
redirect_pc  in  ADDR_W  new fetch target
inst_valid  out  1  queue head valid
inst_ready  in  1  decode accepts head
inst_data  out  32  head instruction word
inst_pc  out  ADDR_W  head instruction address
fault  out  1  fetch stopped on bad address
fault_pc  out  ADDR_W  offending address, valid while fault=1

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC, queue empty (rd_ptr=wr_ptr=0, count=0), state=FETCH, inst_valid=0, inst_data=0, inst_pc=0, fault=0, fault_pc=0. Outputs stay at reset values until first rising edge after rst_n deasserts.
- States: FETCH, FAULT.
- Address check (combinational on fetch_pc): bad if fetch_pc[1:0]!=0 or fetch_pc > IMEM_BYTES-4 (unsigned, full ADDR_W compare).
- pop = inst_valid & inst_ready. push = state==FETCH & !bad & !redirect_valid & (count<DEPTH | pop).
- Push: write {fetch_pc, imem_instr} at wr_ptr, wr_ptr+1 mod DEPTH, fetch_pc+=4.
- Pop: rd_ptr+1 mod DEPTH. Simultaneous push and pop: count unchanged, legal when full.
- Latency: word fetched at edge N is visible on inst_* in cycle N+1. Back-to-back throughput 1 instr/cycle with inst_ready held high.
- inst_valid = count!=0; inst_data/inst_pc driven from head entry (registered storage, no comb path from imem_instr). inst_data/inst_pc hold last head value when empty (don't-care, but stable).
- Stall: inst_ready=0 with full queue -> no push, fetch_pc holds, head stable; no entry lost or duplicated.
- Redirect (highest priority, any state): at edge, queue flushed (count=0, pointers to 0), fetch_pc=redirect_pc, state=FETCH, fault=0. No push and no pop counted that cycle, even if inst_ready=1 (head in that cycle is discarded). inst_valid=0 in following cycle; first redirected instruction valid 2 cycles after redirect edge... precisely: redirect at edge R, push at edge R+1, inst_valid at cycle after R+1.
- FETCH -> FAULT: at edge where state==FETCH, !redirect_valid, bad=1: fault=1, fault_pc=fetch_pc. No push. Queued entries still drain normally.
- FAULT: no fetch; fetch_pc holds; exits only via redirect_valid (or reset).
- Wrap: pointers wrap mod DEPTH; fetch_pc does not wrap into memory - running off end (fetch_pc=IMEM_BYTES) faults.
- fetch_pc increment is ADDR_W-bit, overflow truncated (caught by range check).

Decomposition:
- Shared package: state encoding (FETCH, FAULT), instruction width constant (32), bytes-per-instruction (4).
- Sub-module: fetch_queue (DEPTH-entry synchronous FIFO, {pc,instr} payload, push/pop/flush, count, full/empty); controller holds fetch_pc, FSM and fault capture.

Test Plan:
- Reset release, inst_ready=1, memory words W0..W15 -> inst_valid rises cycle after first edge; inst_pc 0,4,8,... with W0,W1,... one per cycle.
- inst_ready=0 for 10 cycles from reset -> exactly 4 pushes, imem_addr stalls at 0x10, head stays pc=0/W0; release ready -> pcs 0,4,8,12,16 in order, no gaps.
- Run to end (IMEM_BYTES=64) -> last delivered pc=0x3C, fault=1 with fault_pc=0x40, fetching stops, inst_valid drops after drain.
- redirect_valid with redirect_pc=0x20 while queue holds 3 entries and inst_ready=1 -> queue flushed, next delivered inst_pc=0x20, nothing from old stream appears.
- redirect_pc=0x22 -> fault=1, fault_pc=0x22, no push; then redirect_pc=0x08 -> fault=0, stream resumes at 0x08.
- rst_n asserted mid-stream with full queue -> all outputs zero immediately (async), after release stream restarts at RESET_PC.
